// File: rtl/camera_stream_pkg.sv
// Shared constants for the camera stream encoder/decoder pair: marker framing,
// compression mode codes and delta predictor parameters.
package camera_stream_pkg;
  localparam logic [7:0] MARKER_BYTE  = 8'hAA;
  localparam int         MARKER_COUNT = 3;
  localparam logic [2:0] MODE_RAW     = 3'b000;
  localparam logic [2:0] MODE_DOWN    = 3'b100;
  localparam logic [2:0] MODE_DELTA   = 3'b111;
  localparam logic [7:0] DELTA_STEP   = 8'd16;
  localparam int         DELTA_GROUP  = 33;

  typedef enum logic {ST_HUNT = 1'b0, ST_DATA = 1'b1} state_t;

  function automatic logic mode_ok(input logic [2:0] m);
    return (m == MODE_RAW) || (m == MODE_DOWN) || (m == MODE_DELTA);
  endfunction
endpackage

// File: rtl/delta_step_unit.sv
// Saturating +/-DELTA_STEP predictor update used by delta decoding.
module delta_step_unit
  import camera_stream_pkg::*;
(
  input  logic [7:0] pred_i,
  input  logic       dir_i,
  output logic [7:0] pred_o
);
  localparam logic [7:0] HI_LIM = 8'hFF - DELTA_STEP + 8'd1;

  always_comb begin
    if (dir_i) pred_o = (pred_i < HI_LIM)     ? pred_i + DELTA_STEP : 8'hFF;
    else       pred_o = (pred_i >= DELTA_STEP) ? pred_i - DELTA_STEP : 8'h00;
  end
endmodule

// File: rtl/camera_stream_decoder.sv
// Marker-framed camera byte stream decoder: hunts for the AA AA AA marker, then
// expands raw / downsampled / delta-coded bytes into a ready/valid pixel stream.
module camera_stream_decoder
  import camera_stream_pkg::*;
#(
  parameter int FRAME_PIXELS = 76800
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [2:0] decode_mode,
  input  logic       pixel_ready,
  output logic [7:0] pixel_out,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       mode_err
);
  localparam int CW = $clog2(FRAME_PIXELS + 1);
  localparam int GW = $clog2(DELTA_GROUP);

  state_t        state_q, state_d;
  logic [1:0]    mark_q, mark_d;
  logic [2:0]    mode_q, mode_d;
  logic [7:0]    hold_byte_q, hold_byte_d;
  logic          hold_full_q, hold_full_d;
  logic          hold_ref_q, hold_ref_d;
  logic [2:0]    sub_q, sub_d;
  logic [GW-1:0] grp_q, grp_d, grp_next;
  logic [CW-1:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]    pred_q, pred_d, pix_q, pix_d;
  logic          fs_q, fs_d, fd_q, fd_d, me_q, me_d;

  logic       pop, accept, last_in_byte, frame_end, marker_done, step_dir;
  logic [7:0] step_out;

  // Only one pixel is generated per cycle, so a single step unit is shared
  // between "first pixel of a newly popped byte" and "next bit of held byte".
  assign step_dir = pop ? fifo_data[7] : hold_byte_q[3'd6 - sub_q];

  delta_step_unit u_step (.pred_i(pred_q), .dir_i(step_dir), .pred_o(step_out));

  always_ff @(posedge pclk) begin
    if (reset) state_q <= ST_HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT: if (marker_done && mode_ok(decode_mode)) state_d = ST_DATA;
      ST_DATA: if (frame_end) state_d = ST_HUNT;
      default: state_d = ST_HUNT;
    endcase
  end

  always_comb begin
    accept = hold_full_q & pixel_ready;
    case (mode_q)
      MODE_DOWN:  last_in_byte = (sub_q == 3'd1);
      MODE_DELTA: last_in_byte = hold_ref_q | (sub_q == 3'd7);
      default:    last_in_byte = 1'b1;
    endcase
    frame_end   = accept && (pix_cnt_q == CW'(FRAME_PIXELS - 1));
    pop         = !reset && !fifo_empty &&
                  (state_q == ST_HUNT || !hold_full_q || (accept && last_in_byte && !frame_end));
    marker_done = (state_q == ST_HUNT) && pop && (fifo_data == MARKER_BYTE) &&
                  (mark_q == 2'(MARKER_COUNT - 1));
    grp_next    = (grp_q == GW'(DELTA_GROUP - 1)) ? '0 : grp_q + GW'(1);
  end

  always_comb begin
    mark_d      = mark_q;
    mode_d      = mode_q;
    hold_byte_d = hold_byte_q;
    hold_full_d = hold_full_q;
    hold_ref_d  = hold_ref_q;
    sub_d       = sub_q;
    grp_d       = grp_q;
    pix_cnt_d   = pix_cnt_q;
    pred_d      = pred_q;
    pix_d       = pix_q;
    fs_d        = 1'b0;
    fd_d        = 1'b0;
    me_d        = 1'b0;
    if (state_q == ST_HUNT) begin
      if (pop) begin
        if (fifo_data != MARKER_BYTE) mark_d = '0;
        else if (!marker_done)        mark_d = mark_q + 2'd1;
        else begin
          mark_d = '0;
          if (mode_ok(decode_mode)) begin
            mode_d    = decode_mode;
            fs_d      = 1'b1;
            pix_cnt_d = '0;
            grp_d     = '0;
            pred_d    = '0;
          end else begin
            me_d = 1'b1;
          end
        end
      end
    end else begin
      if (accept) begin
        pix_cnt_d = pix_cnt_q + CW'(1);
        if (last_in_byte) hold_full_d = 1'b0;
        else begin
          sub_d = sub_q + 3'd1;
          if (mode_q == MODE_DELTA) begin
            pix_d  = step_out;
            pred_d = step_out;
            grp_d  = grp_next;
          end else begin
            pix_d = {hold_byte_q[3:0], 4'h0};
          end
        end
      end
      // Leftover bits of the final byte are dropped with the frame.
      if (frame_end) begin
        hold_full_d = 1'b0;
        fd_d        = 1'b1;
        mark_d      = '0;
      end
      if (pop) begin
        hold_byte_d = fifo_data;
        hold_full_d = 1'b1;
        hold_ref_d  = 1'b0;
        sub_d       = '0;
        case (mode_q)
          MODE_DOWN: pix_d = {fifo_data[7:4], 4'h0};
          MODE_DELTA: begin
            grp_d = grp_next;
            if (grp_q == '0) begin
              pix_d      = fifo_data;
              pred_d     = fifo_data;
              hold_ref_d = 1'b1;
            end else begin
              pix_d  = step_out;
              pred_d = step_out;
            end
          end
          default: pix_d = fifo_data;
        endcase
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      mark_q      <= '0;
      mode_q      <= MODE_RAW;
      hold_byte_q <= '0;
      hold_full_q <= 1'b0;
      hold_ref_q  <= 1'b0;
      sub_q       <= '0;
      grp_q       <= '0;
      pix_cnt_q   <= '0;
      pred_q      <= '0;
      pix_q       <= '0;
      fs_q        <= 1'b0;
      fd_q        <= 1'b0;
      me_q        <= 1'b0;
    end else begin
      mark_q      <= mark_d;
      mode_q      <= mode_d;
      hold_byte_q <= hold_byte_d;
      hold_full_q <= hold_full_d;
      hold_ref_q  <= hold_ref_d;
      sub_q       <= sub_d;
      grp_q       <= grp_d;
      pix_cnt_q   <= pix_cnt_d;
      pred_q      <= pred_d;
      pix_q       <= pix_d;
      fs_q        <= fs_d;
      fd_q        <= fd_d;
      me_q        <= me_d;
    end
  end

  always_comb begin
    fifo_rd_en  = pop;
    pixel_out   = pix_q;
    pixel_valid = hold_full_q;
    frame_start = fs_q;
    frame_done  = fd_q;
    mode_err    = me_q;
  end
endmodule

// File: tb/tb_camera_stream_decoder.sv
// Scoreboard bench: two decoder instances (4- and 33-pixel frames) share one
// byte FIFO model; a negedge monitor checks pixels and protocol.
module tb_camera_stream_decoder;
  typedef logic [7:0] bq_t[$];

  logic       pclk = 1'b0;
  logic       reset, sel;
  logic [7:0] fifo_data;
  logic       fifo_empty, pixel_ready;
  logic [2:0] decode_mode;
  logic [1:0] empty_x, rd_en, valid, fs, fd, me;
  logic [7:0] pout0, pout1;
  logic       m_rd, m_empty, m_valid, m_fs, m_fd, m_me;
  logic [7:0] m_pout;

  bq_t fq, eq;
  int  n_chk = 0, n_fail = 0;
  int  fs_cnt = 0, fd_cnt = 0, me_cnt = 0, acc_cnt = 0, frame_pix = 0, cyc = 0;
  bit  bp_en = 0, gap_en = 0, pop_pend = 0, stall_prev = 0;
  logic [7:0] prev_pout = 8'h00;

  always #5 pclk = ~pclk;

  assign empty_x[0] = fifo_empty | sel;
  assign empty_x[1] = fifo_empty | ~sel;

  camera_stream_decoder #(.FRAME_PIXELS(4)) dut0 (
    .pclk(pclk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(empty_x[0]),
    .fifo_rd_en(rd_en[0]), .decode_mode(decode_mode), .pixel_ready(pixel_ready),
    .pixel_out(pout0), .pixel_valid(valid[0]), .frame_start(fs[0]),
    .frame_done(fd[0]), .mode_err(me[0]));

  camera_stream_decoder #(.FRAME_PIXELS(33)) dut1 (
    .pclk(pclk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(empty_x[1]),
    .fifo_rd_en(rd_en[1]), .decode_mode(decode_mode), .pixel_ready(pixel_ready),
    .pixel_out(pout1), .pixel_valid(valid[1]), .frame_start(fs[1]),
    .frame_done(fd[1]), .mode_err(me[1]));

  always_comb begin
    m_rd    = sel ? rd_en[1]   : rd_en[0];
    m_empty = sel ? empty_x[1] : empty_x[0];
    m_valid = sel ? valid[1]   : valid[0];
    m_pout  = sel ? pout1      : pout0;
    m_fs    = sel ? fs[1]      : fs[0];
    m_fd    = sel ? fd[1]      : fd[0];
    m_me    = sel ? me[1]      : me[0];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: all inputs change 1 time unit after the rising edge.
  initial begin
    fifo_data = 8'h00; fifo_empty = 1'b1; pixel_ready = 1'b1;
    forever begin
      @(posedge pclk); #1;
      cyc++;
      if (pop_pend && fq.size() > 0) void'(fq.pop_front());
      pop_pend    = 0;
      pixel_ready = bp_en ? ~pixel_ready : 1'b1;
      fifo_empty  = (fq.size() == 0) || (gap_en && (cyc % 3 == 0));
      fifo_data   = (fq.size() > 0) ? fq[0] : 8'h00;
    end
  end

  always @(negedge pclk) begin
    pop_pend = m_rd;
    if (!reset) begin
      chk("no_pop_when_empty", int'(m_rd & m_empty), 0);
      if (m_fs) begin fs_cnt++; frame_pix = 0; end
      if (m_me) me_cnt++;
      if (m_fd) begin fd_cnt++; chk("frame_done_pixels", frame_pix, sel ? 33 : 4); end
      if (stall_prev) begin
        chk("stall_valid_held", int'(m_valid), 1);
        chk("stall_pixel_stable", int'(m_pout), int'(prev_pout));
      end
      if (m_valid && !pixel_ready) chk("no_pop_while_stalled", int'(m_rd), 0);
      if (m_valid && pixel_ready) begin
        acc_cnt++; frame_pix++;
        chk("pixel_expected", int'(eq.size() > 0), 1);
        if (eq.size() > 0) chk("pixel_value", int'(m_pout), int'(eq.pop_front()));
      end
      stall_prev = m_valid && !pixel_ready;
      prev_pout  = m_pout;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((eq.size() != 0 || fq.size() != 0) && n < 2000) begin tick(1); n++; end
    chk({name, "_drained"}, int'(eq.size() == 0 && fq.size() == 0), 1);
    eq.delete(); fq.delete();
    tick(4);
  endtask

  task automatic run(input string name, input bq_t bytes, input bq_t exp);
    int fs0 = fs_cnt, fd0 = fd_cnt;
    foreach (exp[i])   eq.push_back(exp[i]);
    foreach (bytes[i]) fq.push_back(bytes[i]);
    drain(name);
    chk({name, "_frame_start"}, fs_cnt - fs0, 1);
    chk({name, "_frame_done"},  fd_cnt - fd0, 1);
  endtask

  function automatic bq_t delta_exp();
    bq_t e;
    e.push_back(8'hF8);
    repeat (8) e.push_back(8'hFF);
    for (int i = 0; i < 8; i++) e.push_back(8'(239 - 16 * i));
    for (int i = 0; i < 8; i++) e.push_back(8'(143 + 16 * i));
    for (int i = 0; i < 8; i++) e.push_back(8'(239 - 16 * i));
    return e;
  endfunction

  task automatic chk_idle(input string name, input int d);
    chk({name, "_valid"}, int'(valid[d]), 0);
    chk({name, "_pixel"}, int'(d ? pout1 : pout0), 0);
    chk({name, "_fs"},    int'(fs[d]), 0);
    chk({name, "_fd"},    int'(fd[d]), 0);
    chk({name, "_me"},    int'(me[d]), 0);
    chk({name, "_rd_en"}, int'(rd_en[d]), 0);
  endtask

  initial begin
    bq_t dbytes, dexp;
    int  me0, acc0, fd0, n;
    dbytes = '{8'hAA, 8'hAA, 8'hAA, 8'hF8, 8'hFF, 8'h00, 8'hFF, 8'h00};
    dexp   = delta_exp();
    reset = 1'b1; sel = 1'b0; decode_mode = 3'b000;
    tick(3);
    chk_idle("reset0", 0);
    chk_idle("reset1", 1);
    reset = 1'b0;
    tick(2);

    run("raw",    '{8'hAA, 8'hAA, 8'hAA, 8'h12, 8'hAA, 8'h34, 8'h56}, '{8'h12, 8'hAA, 8'h34, 8'h56});
    decode_mode = 3'b100;
    run("down",   '{8'hAA, 8'hAA, 8'hAA, 8'h5C, 8'h3F}, '{8'h50, 8'hC0, 8'h30, 8'hF0});
    decode_mode = 3'b000;
    run("resync", '{8'h00, 8'hAA, 8'hAA, 8'h07, 8'hAA, 8'hAA, 8'hAA, 8'h42, 8'h01, 8'h02, 8'h03},
                  '{8'h42, 8'h01, 8'h02, 8'h03});

    bp_en = 1; gap_en = 1;
    run("raw_bp",  '{8'hAA, 8'hAA, 8'hAA, 8'h11, 8'h22, 8'h33, 8'h44}, '{8'h11, 8'h22, 8'h33, 8'h44});
    decode_mode = 3'b100;
    run("down_bp", '{8'hAA, 8'hAA, 8'hAA, 8'h5C, 8'h3F}, '{8'h50, 8'hC0, 8'h30, 8'hF0});
    bp_en = 0; gap_en = 0;

    sel = 1'b1; decode_mode = 3'b111;
    tick(2);
    run("delta", dbytes, dexp);
    bp_en = 1; gap_en = 1;
    run("delta_bp", dbytes, dexp);
    bp_en = 0; gap_en = 0;

    sel = 1'b0; decode_mode = 3'b010;
    tick(2);
    me0 = me_cnt; acc0 = acc_cnt;
    fq.push_back(8'hAA); fq.push_back(8'hAA); fq.push_back(8'hAA);
    drain("bad_mode");
    chk("bad_mode_err",    me_cnt - me0, 1);
    chk("bad_mode_pixels", acc_cnt - acc0, 0);
    decode_mode = 3'b000;
    run("after_err", '{8'hAA, 8'hAA, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04}, '{8'h01, 8'h02, 8'h03, 8'h04});

    // Reset partway through the first bit group of a delta frame.
    sel = 1'b1; decode_mode = 3'b111;
    tick(2);
    fd0 = fd_cnt; acc0 = acc_cnt; n = 0;
    foreach (dexp[i])   eq.push_back(dexp[i]);
    foreach (dbytes[i]) fq.push_back(dbytes[i]);
    while (acc_cnt - acc0 < 5 && n < 200) begin tick(1); n++; end
    chk("midframe_progress", int'(acc_cnt - acc0 >= 5), 1);
    reset = 1'b1; eq.delete(); fq.delete();
    tick(1);
    chk_idle("midreset", 1);
    tick(1);
    reset = 1'b0;
    tick(3);
    chk("midreset_no_done", fd_cnt - fd0, 0);
    chk("midreset_quiet",   int'(valid[1]), 0);
    run("delta_after_reset", dbytes, dexp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
